cmag_pipe: RTL and testbench

Parametrised, fully pipelined complex-magnitude estimator. It is the successor to the three-cycle, one-sample-per-three-clocks magnitude approximator used in the short-preamble synchronisation path. The block accepts one I/Q sample per clock with ready/valid backpressure and carries a per-sample mode and tag. It selects one of three alpha-max-plus-beta-min estimators per sample and feeds the sync correlator/threshold logic.

---
 rtl/cmag_pipe.sv | 95 +++++++++
 tb/tb_cmag_pipe.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/cmag_pipe.sv
// Three-stage alpha-max-plus-beta-min complex magnitude estimator, one I/Q sample per clock.
// Each stage carries a valid bit plus mode and tag; bubbles collapse and stalls hold from the output back.
module cmag_pipe #(
   parameter int W     = 32,
   parameter int TAG_W = 8
) (
   input  logic                CLK,
   input  logic                s_RST_n,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic signed [W-1:0] i,
   input  logic signed [W-1:0] q,
   input  logic [1:0]          mode,
   input  logic [TAG_W-1:0]    in_tag,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [W-1:0]        mag,
   output logic [TAG_W-1:0]    out_tag
);

   // A beat moves on a side when valid && ready are both high at a rising edge;
   // the producer may change its data freely on any cycle where no beat moved.
   logic             s1_v, s2_v;
   logic [W-1:0]     s1_ai, s1_aq, s2_mx, s2_mn;
   logic [1:0]       s1_mode, s2_mode;
   logic [TAG_W-1:0] s1_tag, s2_tag;

   logic en1, en2, en3;
   logic [W-1:0] abs_i, abs_q, mag_next, alt;

   assign en3      = !out_valid || out_ready;
   assign en2      = !s2_v || en3;
   assign en1      = !s1_v || en2;
   assign in_ready = s_RST_n && en1;

   // Negating -2^(W-1) wraps to itself, which read as unsigned is exactly 2^(W-1).
   assign abs_i = i[W-1] ? $unsigned(-i) : $unsigned(i);
   assign abs_q = q[W-1] ? $unsigned(-q) : $unsigned(q);

   always_comb begin
      mag_next = s2_mx + (s2_mn >> 2);
      alt      = s2_mx - (s2_mx >> 3) + (s2_mn >> 1);
      case (s2_mode)
         2'd1:    mag_next = s2_mx + (s2_mn >> 2) + (s2_mn >> 3);
         2'd2:    mag_next = (alt > s2_mx) ? alt : s2_mx;
         default: mag_next = s2_mx + (s2_mn >> 2);
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!s_RST_n) begin
         s1_v      <= 1'b0;
         s2_v      <= 1'b0;
         out_valid <= 1'b0;
         s1_ai     <= '0;
         s1_aq     <= '0;
         s1_mode   <= '0;
         s1_tag    <= '0;
         s2_mx     <= '0;
         s2_mn     <= '0;
         s2_mode   <= '0;
         s2_tag    <= '0;
         mag       <= '0;
         out_tag   <= '0;
      end else begin
         if (en1) begin
            s1_v <= in_valid;
            if (in_valid) begin
               s1_ai   <= abs_i;
               s1_aq   <= abs_q;
               s1_mode <= mode;
               s1_tag  <= in_tag;
            end
         end
         if (en2) begin
            s2_v <= s1_v;
            if (s1_v) begin
               s2_mx   <= (s1_ai >= s1_aq) ? s1_ai : s1_aq;
               s2_mn   <= (s1_ai >= s1_aq) ? s1_aq : s1_ai;
               s2_mode <= s1_mode;
               s2_tag  <= s1_tag;
            end
         end
         // Output data only loads with a real sample, so it stays put while stalled.
         if (en3) begin
            out_valid <= s2_v;
            if (s2_v) begin
               mag     <= mag_next;
               out_tag <= s2_tag;
            end
         end
      end
   end

endmodule

// File: tb/tb_cmag_pipe.sv
// Directed bench for cmag_pipe: estimator values, extremes, throughput, backpressure,
// bubble collapse and mid-stream reset, with a queue scoreboard fed by a reference model.
module tb_cmag_pipe;

  logic               CLK = 1'b0;
  logic               s_RST_n;
  logic               in_valid, in_ready, out_valid, out_ready;
  logic signed [31:0] i, q;
  logic [1:0]         mode;
  logic [7:0]         in_tag, out_tag;
  logic [31:0]        mag;

  int n_cmp, n_bad;

  logic [39:0] exp_q[$];
  logic        prev_stall;
  logic [31:0] prev_mag;
  logic [7:0]  prev_tag;

  always #5 CLK = ~CLK;

  cmag_pipe #(.W(32), .TAG_W(8)) dut (
    .CLK(CLK), .s_RST_n(s_RST_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .i(i), .q(q), .mode(mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .mag(mag), .out_tag(out_tag)
  );

  function automatic logic [31:0] ref_mag(input logic signed [31:0] xi, input logic signed [31:0] xq,
                                          input logic [1:0] m);
    longint ai, aq, mx, mn, r;
    ai = (xi < 0) ? -longint'(xi) : longint'(xi);
    aq = (xq < 0) ? -longint'(xq) : longint'(xq);
    mx = (ai >= aq) ? ai : aq;
    mn = (ai >= aq) ? aq : ai;
    case (m)
      2'd1: r = mx + mn / 4 + mn / 8;
      2'd2: begin
        r = mx - mx / 8 + mn / 2;
        if (r < mx) r = mx;
      end
      default: r = mx + mn / 4;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // scoreboard: samples at negedge, away from the active edge
  always @(negedge CLK) begin
    if (!s_RST_n) begin
      exp_q.delete();
      prev_stall = 1'b0;
    end else begin
      check("ready_rule", {31'd0, in_ready}, {31'd0, (exp_q.size() < 3) || out_ready});
      if (prev_stall) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_mag", mag, prev_mag);
        check("hold_tag", {24'd0, out_tag}, {24'd0, prev_tag});
      end
      if (out_valid && out_ready) begin
        n_cmp++;
        assert (exp_q.size() != 0) else begin
          n_bad++;
          $error("FAIL spurious_out: observed tag %h mag %h expected no output", out_tag, mag);
        end
        if (exp_q.size() != 0) begin
          logic [39:0] e;
          e = exp_q.pop_front();
          check("sb_mag", mag, e[31:0]);
          check("sb_tag", {24'd0, out_tag}, {24'd0, e[39:32]});
        end
      end
      if (in_valid && in_ready) exp_q.push_back({in_tag, ref_mag(i, q, mode)});
      prev_stall = out_valid && !out_ready;
      prev_mag   = mag;
      prev_tag   = out_tag;
    end
  end

  // one sample with out_ready high; result must appear exactly three cycles later
  task automatic est(input logic signed [31:0] vi, input logic signed [31:0] vq,
                     input logic [1:0] vm, input logic [7:0] vt, input logic [31:0] exp);
    @(posedge CLK); #1;
    in_valid = 1'b1; i = vi; q = vq; mode = vm; in_tag = vt;
    @(negedge CLK);
    check("est_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    @(negedge CLK);
    check("est_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge CLK);
    check("est_lat2", {31'd0, out_valid}, 32'd0);
    @(negedge CLK);
    check("est_valid", {31'd0, out_valid}, 32'd1);
    check("est_mag", mag, exp);
    check("est_tag", {24'd0, out_tag}, {24'd0, vt});
  endtask

  initial begin
    #500000;
    $display("FAIL timeout: observed no finish expected finish within bound");
    $fatal(1);
  end

  initial begin
    logic bpat[5];
    int   acc, nb;
    n_cmp = 0; n_bad = 0;
    s_RST_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    i = '0; q = '0; mode = '0; in_tag = '0;

    // reset state
    repeat (3) begin
      @(negedge CLK);
      check("rst_in_ready", {31'd0, in_ready}, 32'd0);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    end
    @(posedge CLK); #1;
    s_RST_n = 1'b1;
    @(negedge CLK);
    check("post_rst_ready", {31'd0, in_ready}, 32'd1);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_mag", mag, 32'd0);
    check("post_rst_tag", {24'd0, out_tag}, 32'd0);

    // estimator values and extremes
    est(32'sd100, -32'sd40, 2'd0, 8'h10, 32'd110);
    est(32'sd100, -32'sd40, 2'd1, 8'h11, 32'd115);
    est(32'sd100, -32'sd40, 2'd2, 8'h12, 32'd108);
    est(32'sd100, -32'sd40, 2'd3, 8'h13, 32'd110);
    est(32'h80000000, 32'sd0, 2'd0, 8'h14, 32'h80000000);
    est(32'h80000000, 32'h80000000, 2'd1, 8'h15, 32'hB0000000);
    est(32'sd0, 32'sd0, 2'd0, 8'h16, 32'd0);
    est(32'sd100, 32'sd0, 2'd2, 8'h17, 32'd100);
    est(-32'sd50, 32'sd50, 2'd0, 8'h18, 32'd62);

    // throughput: 64 back-to-back samples
    for (int c = 0; c < 67; c++) begin
      @(posedge CLK); #1;
      if (c < 64) begin
        in_valid = 1'b1; i = $urandom; q = $urandom; mode = 2'($urandom_range(0, 3)); in_tag = c[7:0];
      end else begin
        in_valid = 1'b0;
      end
      @(negedge CLK);
      if (c < 64) check("tp_in_ready", {31'd0, in_ready}, 32'd1);
      if (c >= 3) begin
        check("tp_out_valid", {31'd0, out_valid}, 32'd1);
        check("tp_out_tag", {24'd0, out_tag}, c - 3);
      end
    end
    @(posedge CLK); #1;
    @(negedge CLK);
    check("tp_drained", exp_q.size(), 32'd0);

    // random backpressure over 1000 accepted samples
    acc = 0;
    for (int c = 0; c < 6000 && acc < 1000; c++) begin
      @(posedge CLK); #1;
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = ($urandom_range(0, 3) != 0);
      i = $urandom; q = $urandom; mode = 2'($urandom_range(0, 3)); in_tag = acc[7:0];
      @(negedge CLK);
      if (in_valid && in_ready) acc++;
    end
    check("bp_accepted", acc, 32'd1000);
    @(posedge CLK); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (5) @(negedge CLK);
    check("bp_drained", exp_q.size(), 32'd0);

    // bubbles collapse under a stalled output
    bpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    nb = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLK); #1;
      out_ready = 1'b0;
      in_valid  = bpat[c];
      i = 32'sd7 * (c + 1); q = -32'sd3 * (c + 1); mode = 2'(c); in_tag = 8'hB0 + nb[7:0];
      @(negedge CLK);
      if (in_valid && in_ready) nb++;
    end
    check("bub_accepted", nb, 32'd3);
    @(posedge CLK); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge CLK);
      check("bub_valid", {31'd0, out_valid}, 32'd1);
      check("bub_tag", {24'd0, out_tag}, 32'hB0 + c);
    end
    @(negedge CLK);
    check("bub_done", {31'd0, out_valid}, 32'd0);

    // mid-stream reset with a full pipe
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      out_ready = 1'b0;
      in_valid = 1'b1; i = 32'sd1000 + c; q = 32'sd200; mode = 2'd0; in_tag = 8'hC0 + 8'(c);
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    in_valid = 1'b0; s_RST_n = 1'b0;
    @(negedge CLK);
    check("mrst_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge CLK); #1;
    s_RST_n = 1'b1; out_ready = 1'b1;
    @(negedge CLK);
    check("mrst_valid", {31'd0, out_valid}, 32'd0);
    check("mrst_mag", mag, 32'd0);
    check("mrst_tag", {24'd0, out_tag}, 32'd0);
    check("mrst_ready", {31'd0, in_ready}, 32'd1);
    repeat (4) begin
      @(negedge CLK);
      check("mrst_no_stale", {31'd0, out_valid}, 32'd0);
    end
    est(32'sd300, -32'sd400, 2'd1, 8'hD0, 32'd512);

    repeat (3) @(negedge CLK);
    check("final_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
